// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM frame arbiter.
package sdram_arb_pkg;

  localparam int unsigned AddrWDefault     = 25;
  localparam int unsigned DataWDefault     = 16;
  localparam int unsigned BurstWDefault    = 4;
  localparam int unsigned StarveMaxDefault = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StRdata
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnVga,
    OwnCpu
  } arb_owner_e;

endpackage

// File: rtl/sdram_arb_starve_ctr.sv
// Saturating count of VGA grants issued while the CPU waits; trips at Max.
module sdram_arb_starve_ctr #(
  parameter int unsigned Max = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic trip_o
);

  localparam int unsigned CntW = $clog2(Max + 1);

  logic [CntW-1:0] cnt_q;

  assign trip_o = (cnt_q >= CntW'(Max));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !trip_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Two-master (VGA DMA, Nios CPU) arbiter in front of the SDRAM controller.
// Optional CPU anti-starvation guard: define ARB_STARVE_GUARD_EN.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned BURST_W    = BurstWDefault,
  parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [ADDR_W-1:0]  vga_address,
  input  logic               vga_read,
  input  logic [BURST_W-1:0] vga_burstcount,
  output logic               vga_waitrequest,
  output logic [DATA_W-1:0]  vga_readdata,
  output logic               vga_readdatavalid,
  input  logic [ADDR_W-1:0]  cpu_address,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [DATA_W-1:0]  cpu_writedata,
  input  logic [1:0]         cpu_byteenable,
  input  logic [BURST_W-1:0] cpu_burstcount,
  output logic               cpu_waitrequest,
  output logic [DATA_W-1:0]  cpu_readdata,
  output logic               cpu_readdatavalid,
  output logic [ADDR_W-1:0]  sdr_address,
  output logic               sdr_read,
  output logic               sdr_write,
  output logic [DATA_W-1:0]  sdr_writedata,
  output logic [1:0]         sdr_byteenable,
  output logic [BURST_W-1:0] sdr_burstcount,
  input  logic               sdr_waitrequest,
  input  logic [DATA_W-1:0]  sdr_readdata,
  input  logic               sdr_readdatavalid
);

  arb_state_e         state_q;
  arb_owner_e         owner_q;
  logic [BURST_W-1:0] beat_q;
  logic [BURST_W-1:0] burst_eff;
  logic               cpu_req;
  logic               vga_pick;
  logic               in_rdata;

  assign cpu_req = cpu_read | cpu_write;

`ifdef ARB_STARVE_GUARD_EN
  logic starve_trip;

  sdram_arb_starve_ctr #(
    .Max (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .inc_i  ((state_q == StIdle) && vga_pick && cpu_req),
    .clr_i  (!cpu_req || ((state_q == StIdle) && !vga_pick && cpu_req)),
    .trip_o (starve_trip)
  );

  // Once tripped, a waiting CPU takes the next IDLE decision over VGA.
  assign vga_pick = vga_read && !(starve_trip && cpu_req);
`else
  assign vga_pick = vga_read;
`endif

  // Command path: live mux of the owning master while in CMD, idle otherwise.
  always_comb begin
    sdr_address     = '0;
    sdr_read        = 1'b0;
    sdr_write       = 1'b0;
    sdr_writedata   = '0;
    sdr_byteenable  = '0;
    sdr_burstcount  = '0;
    vga_waitrequest = 1'b1;
    cpu_waitrequest = 1'b1;
    if (state_q == StCmd) begin
      case (owner_q)
        OwnVga: begin
          sdr_address     = vga_address;
          sdr_read        = vga_read;
          sdr_byteenable  = 2'b11;
          sdr_burstcount  = vga_burstcount;
          vga_waitrequest = sdr_waitrequest;
        end
        OwnCpu: begin
          sdr_address     = cpu_address;
          sdr_read        = cpu_read;
          sdr_write       = cpu_write;
          sdr_writedata   = cpu_writedata;
          sdr_byteenable  = cpu_byteenable;
          sdr_burstcount  = cpu_write ? BURST_W'(1) : cpu_burstcount;
          cpu_waitrequest = sdr_waitrequest;
        end
        default: ;
      endcase
    end
  end

  assign burst_eff = (sdr_burstcount == '0) ? BURST_W'(1) : sdr_burstcount;

  // Return path is combinational; only the valid strobe is steered.
  assign in_rdata          = (state_q == StRdata);
  assign vga_readdata      = sdr_readdata;
  assign cpu_readdata      = sdr_readdata;
  assign vga_readdatavalid = in_rdata && (owner_q == OwnVga) && sdr_readdatavalid;
  assign cpu_readdatavalid = in_rdata && (owner_q == OwnCpu) && sdr_readdatavalid;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      owner_q <= OwnNone;
      beat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (vga_pick) begin
            owner_q <= OwnVga;
            state_q <= StCmd;
          end else if (cpu_req) begin
            owner_q <= OwnCpu;
            state_q <= StCmd;
          end
        end
        StCmd: begin
          if (!(sdr_read || sdr_write)) begin
            // Owner withdrew before acceptance: abandon without issuing.
            owner_q <= OwnNone;
            state_q <= StIdle;
          end else if (!sdr_waitrequest) begin
            if (sdr_write) begin
              owner_q <= OwnNone;
              state_q <= StIdle;
            end else begin
              beat_q  <= burst_eff;
              state_q <= StRdata;
            end
          end
        end
        StRdata: begin
          if (sdr_readdatavalid) begin
            if (beat_q <= BURST_W'(1)) begin
              beat_q  <= '0;
              owner_q <= OwnNone;
              state_q <= StIdle;
            end else begin
              beat_q <= beat_q - BURST_W'(1);
            end
          end
        end
        default: begin
          owner_q <= OwnNone;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
